fp_result_packer: RTL and testbench
===================================

Name: fp_result_packer

Overview:
- Downstream stage of the floating-point adder FSM.
- Consumes the adder's 33-bit internal result (sign, 8-bit biased exponent, 24-bit mantissa with explicit leading one) plus guard/round/sticky bits.
- Rounds, handles exponent overflow and zero/underflow, and packs an IEEE-754 single-precision word.
- Two-stage pipeline with valid/ready handshake on both sides, so the adder can stall on backpressure.

Parameters:
- ROUND_MODE, 0, rounding: 0 = round-to-nearest-even, 1 = truncate (ignore guard/round/sticky).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; clears both pipeline stages
- in_valid  in  1  in_z and in_grs hold a valid adder result
- in_ready  out  1  packer accepts input this cycle
- in_z  in  33  [32] sign, [31:24] biased exponent, [23:0] mantissa with bit 23 = hidden one
- in_grs  in  3  guard, round, sticky ([2] = G, [1] = R, [0] = S)
- out_valid  out  1  out_f holds a packed result
- out_ready  in  1  consumer accepts out_f this cycle
- out_f  out  32  IEEE-754 single: [31] sign, [30:23] exponent, [22:0] fraction

Behaviour:
- Reset (reset = 0, asynchronous): s1_valid = 0, s2_valid = 0, out_valid = 0, out_f = 0, in_ready = 1. Reset asserted mid-operation discards in-flight data without producing output.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Advance rules:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = s1 advances (combinational from out_ready; no skid buffer).
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput: 1 result per cycle.
- Stage 1, round (registered):
  - inc = G & (R | S | man[0]) when ROUND_MODE = 0; inc = 0 when ROUND_MODE = 1.
  - m25 = {1'b0, man} + inc, 25-bit.
  - If m25[24] = 1: man1 = m25[24:1], exp1 = exp + 1, 9-bit. Otherwise man1 = m25[23:0], exp1 = {1'b0, exp}.
  - Register sign, exp1, man1, and zero flag zf = (man == 0) | (exp == 0).
- Stage 2, pack (registered into out_f):
  - zf = 1: out_f = {sign, 31'b0}. Signed zero is preserved; denormals flush to zero.
  - exp1 >= 255: out_f = {sign, 8'hFF, 23'b0} (infinity).
  - Otherwise: out_f = {sign, exp1[7:0], man1[22:0]}.
- Input validity: in_z with exp = 8'hFF is treated as overflow and yields infinity. NaN is never produced.
- Hold rules:
  - While out_valid & !out_ready, out_f and out_valid hold stable.
  - With both stages full and out_ready = 0, in_ready = 0 and no data is lost or duplicated.
- Simultaneous input and output transfer when full: both stages shift in the same cycle; order is preserved.
- in_z and in_grs are don't-care when in_valid = 0.

Optional Feature:
- Macro FP_PACK_FLAGS_EN.
- Defined: adds output port out_flags [2:0], aligned with out_f and valid with out_valid, reset 0.
  - [2] overflow: result forced to infinity.
  - [1] underflow: nonzero mantissa with exp 0 flushed to zero.
  - [0] inexact: any of G/R/S nonzero, or overflow.
- Undefined: port absent; no flag logic; datapath behaviour identical.

Test Plan:
- Basic: in_z = {0, 8'h7F, 24'hC00000}, grs = 000, out_ready = 1 -> out_f = 32'h3FC00000, out_valid 2 cycles after transfer.
- Rounding ties:
  - man = 24'h800001, exp 8'h7F, grs = 100 -> 32'h3F800002 (odd LSB rounds up).
  - man = 24'h800000, grs = 100 -> 32'h3F800000 (even, no increment).
  - ROUND_MODE = 1, man = 24'h800001, grs = 111 -> 32'h3F800001.
- Carry and overflow:
  - man = 24'hFFFFFF, exp 8'h7F, grs = 110 -> 32'h40000000.
  - exp 8'hFE, man 24'hFFFFFF, grs = 111 -> 32'h7F800000; out_flags = 101 with FP_PACK_FLAGS_EN.
- Zero/underflow:
  - sign 1, man 0 -> 32'h80000000.
  - exp 0, man 24'h800000 -> 32'h00000000; out_flags[1] = 1 with FP_PACK_FLAGS_EN.
- Backpressure: stream 4 results, out_ready = 0 for 3 cycles after the first out_valid -> in_ready drops once both stages are full; out_f stays stable; all 4 results emerge in order once out_ready = 1.
- Reset mid-operation: assert reset = 0 with both stages full -> out_valid = 0 and out_f = 0 immediately (asynchronous); after release, in_ready = 1 and the next input produces a correct result with 2-cycle latency.

Source files
------------

// File: rtl/fp_result_packer.sv
`default_nettype none
// ============================================================================
// fp_result_packer : rounds and packs the adder's 33-bit result into IEEE-754
// single precision through a two-stage valid/ready pipeline.
// Optional flags port: define FP_PACK_FLAGS_EN.      Revision: 1.0
// ============================================================================
module fp_result_packer #(
    parameter int ROUND_MODE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [32:0] in_z,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_f
`ifdef FP_PACK_FLAGS_EN
    ,
    output logic [2:0]  out_flags
`endif
);

    logic        w_s1_adv;
    logic        w_s2_adv;
    logic        w_sign;
    logic [7:0]  w_exp;
    logic [23:0] w_man;
    logic        w_inc;
    logic [24:0] w_m25;
    logic [22:0] w_man1;
    logic [8:0]  w_exp1;
    logic        w_zf;
    logic        w_ovf;
    logic [31:0] w_packed;

    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [8:0]  r_s1_exp;
    logic [22:0] r_s1_man;
    logic        r_s1_zf;
    logic        r_s2_valid;
    logic [31:0] r_out_f;

    // Backpressure ripples combinationally from out_ready to in_ready.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_sign = in_z[32];
    assign w_exp  = in_z[31:24];
    assign w_man  = in_z[23:0];

    assign w_inc  = (ROUND_MODE == 0) ?
                    (in_grs[2] & (in_grs[1] | in_grs[0] | w_man[0])) : 1'b0;
    assign w_m25  = {1'b0, w_man} + {24'd0, w_inc};
    // Hidden bit is dropped here; only the fraction is carried forward.
    assign w_man1 = w_m25[24] ? w_m25[23:1] : w_m25[22:0];
    assign w_exp1 = {1'b0, w_exp} + {8'd0, w_m25[24]};
    assign w_zf   = (w_man == 24'd0) || (w_exp == 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= 9'd0;
            r_s1_man   <= 23'd0;
            r_s1_zf    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= w_sign;
                r_s1_exp  <= w_exp1;
                r_s1_man  <= w_man1;
                r_s1_zf   <= w_zf;
            end
        end
    end

    assign w_ovf = !r_s1_zf && (r_s1_exp >= 9'd255);

    always_comb begin
        w_packed = {r_s1_sign, r_s1_exp[7:0], r_s1_man};
        if (r_s1_zf) begin
            w_packed = {r_s1_sign, 31'd0};
        end else if (w_ovf) begin
            w_packed = {r_s1_sign, 8'hFF, 23'd0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_out_f    <= 32'd0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_f <= w_packed;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_f     = r_out_f;

`ifdef FP_PACK_FLAGS_EN
    logic       r_s1_unf;
    logic       r_s1_grs_nz;
    logic [2:0] r_out_flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_unf    <= 1'b0;
            r_s1_grs_nz <= 1'b0;
        end else if (w_s1_adv && in_valid) begin
            r_s1_unf    <= (w_exp == 8'd0) && (w_man != 24'd0);
            r_s1_grs_nz <= |in_grs;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_flags <= 3'd0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_out_flags <= {w_ovf, r_s1_unf, r_s1_grs_nz | w_ovf};
        end
    end

    assign out_flags = r_out_flags;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_result_packer.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for fp_result_packer; a second instance runs in truncate mode.
module tb_fp_result_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [32:0] in_z;
    logic [2:0]  in_grs;
    logic        out_ready;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_f0, out_f1;
`ifdef FP_PACK_FLAGS_EN
    logic [2:0]  out_flags0, out_flags1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_result_packer #(.ROUND_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_z(in_z), .in_grs(in_grs), .out_valid(out_valid0),
        .out_ready(out_ready), .out_f(out_f0)
`ifdef FP_PACK_FLAGS_EN
        , .out_flags(out_flags0)
`endif
    );

    fp_result_packer #(.ROUND_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_z(in_z), .in_grs(in_grs), .out_valid(out_valid1),
        .out_ready(out_ready), .out_f(out_f1)
`ifdef FP_PACK_FLAGS_EN
        , .out_flags(out_flags1)
`endif
    );

    // Drives one transaction into an idle pipeline and captures both results.
    task automatic run_one(input logic [32:0] z, input logic [2:0] g,
                           output logic [31:0] f0, output logic [31:0] f1,
                           output logic [2:0] fl, output int lat);
        int wait_n;
        in_z = z; in_grs = g; in_valid = 1'b1; out_ready = 1'b1;
        wait_n = 0;
        #1;
        while (!in_ready0 && wait_n < 10) begin
            @(posedge clk); #1; wait_n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_z = '0; in_grs = '0;
        lat = 1;
        while (!out_valid0 && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        f0 = out_f0;
        f1 = out_valid1 ? out_f1 : 32'hDEAD_BEEF;
`ifdef FP_PACK_FLAGS_EN
        fl = out_flags0;
`else
        fl = 3'b000;
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_z = '0; in_grs = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid0); end
        checks++;
        if (out_f0 !== 32'h0) begin errors++; $display("FAIL reset_out_f: got %h expected 00000000", out_f0); end
        checks++;
        if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready0); end
`ifdef FP_PACK_FLAGS_EN
        checks++;
        if (out_flags0 !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", out_flags0); end
`endif
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] f0, f1; logic [2:0] fl; int lat;
        run_one({1'b0, 8'h7F, 24'hC00000}, 3'b000, f0, f1, fl, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        checks++;
        if (f0 !== 32'h3FC00000) begin errors++; $display("FAIL basic_value: got %h expected 3fc00000", f0); end
    endtask

    task automatic test_rounding();
        logic [31:0] f0, f1; logic [2:0] fl; int lat;
        run_one({1'b0, 8'h7F, 24'h800001}, 3'b100, f0, f1, fl, lat);
        checks++;
        if (f0 !== 32'h3F800002) begin errors++; $display("FAIL tie_odd: got %h expected 3f800002", f0); end
        checks++;
        if (f1 !== 32'h3F800001) begin errors++; $display("FAIL trunc_tie_odd: got %h expected 3f800001", f1); end
        run_one({1'b0, 8'h7F, 24'h800000}, 3'b100, f0, f1, fl, lat);
        checks++;
        if (f0 !== 32'h3F800000) begin errors++; $display("FAIL tie_even: got %h expected 3f800000", f0); end
        run_one({1'b0, 8'h7F, 24'h800001}, 3'b111, f0, f1, fl, lat);
        checks++;
        if (f1 !== 32'h3F800001) begin errors++; $display("FAIL trunc_grs111: got %h expected 3f800001", f1); end
        checks++;
        if (f0 !== 32'h3F800002) begin errors++; $display("FAIL rne_grs111: got %h expected 3f800002", f0); end
`ifdef FP_PACK_FLAGS_EN
        checks++;
        if (fl !== 3'b001) begin errors++; $display("FAIL inexact_flag: got %b expected 001", fl); end
`endif
    endtask

    task automatic test_carry_overflow();
        logic [31:0] f0, f1; logic [2:0] fl; int lat;
        run_one({1'b0, 8'h7F, 24'hFFFFFF}, 3'b110, f0, f1, fl, lat);
        checks++;
        if (f0 !== 32'h40000000) begin errors++; $display("FAIL carry_renorm: got %h expected 40000000", f0); end
        checks++;
        if (f1 !== 32'h3FFFFFFF) begin errors++; $display("FAIL trunc_no_carry: got %h expected 3fffffff", f1); end
        run_one({1'b0, 8'hFE, 24'hFFFFFF}, 3'b111, f0, f1, fl, lat);
        checks++;
        if (f0 !== 32'h7F800000) begin errors++; $display("FAIL overflow_inf: got %h expected 7f800000", f0); end
        checks++;
        if (f1 !== 32'h7F7FFFFF) begin errors++; $display("FAIL trunc_max_finite: got %h expected 7f7fffff", f1); end
`ifdef FP_PACK_FLAGS_EN
        checks++;
        if (fl !== 3'b101) begin errors++; $display("FAIL overflow_flags: got %b expected 101", fl); end
`endif
        run_one({1'b1, 8'hFF, 24'h800000}, 3'b000, f0, f1, fl, lat);
        checks++;
        if (f0 !== 32'hFF800000) begin errors++; $display("FAIL exp_ff_inf: got %h expected ff800000", f0); end
`ifdef FP_PACK_FLAGS_EN
        checks++;
        if (fl !== 3'b101) begin errors++; $display("FAIL exp_ff_flags: got %b expected 101", fl); end
`endif
    endtask

    task automatic test_zero();
        logic [31:0] f0, f1; logic [2:0] fl; int lat;
        run_one({1'b1, 8'h7F, 24'h000000}, 3'b000, f0, f1, fl, lat);
        checks++;
        if (f0 !== 32'h80000000) begin errors++; $display("FAIL neg_zero: got %h expected 80000000", f0); end
`ifdef FP_PACK_FLAGS_EN
        checks++;
        if (fl !== 3'b000) begin errors++; $display("FAIL zero_flags: got %b expected 000", fl); end
`endif
        run_one({1'b0, 8'h00, 24'h800000}, 3'b000, f0, f1, fl, lat);
        checks++;
        if (f0 !== 32'h00000000) begin errors++; $display("FAIL underflow_flush: got %h expected 00000000", f0); end
`ifdef FP_PACK_FLAGS_EN
        checks++;
        if (fl !== 3'b010) begin errors++; $display("FAIL underflow_flags: got %b expected 010", fl); end
`endif
    endtask

    task automatic test_backpressure();
        logic [32:0] vz [4];
        logic [2:0]  vg [4];
        logic [31:0] ve [4];
        logic [31:0] held;
        int ni, no, stall, cyc;
        bit started, saw_block;
        vz[0] = {1'b0, 8'h7F, 24'hC00000}; vg[0] = 3'b000; ve[0] = 32'h3FC00000;
        vz[1] = {1'b0, 8'h80, 24'hA00000}; vg[1] = 3'b000; ve[1] = 32'h40200000;
        vz[2] = {1'b1, 8'h81, 24'h900000}; vg[2] = 3'b000; ve[2] = 32'hC0900000;
        vz[3] = {1'b0, 8'h82, 24'hFFFFFF}; vg[3] = 3'b100; ve[3] = 32'h41800000;
        ni = 0; no = 0; stall = 0; cyc = 0; started = 0; saw_block = 0; held = '0;
        while (no < 4 && cyc < 40) begin
            if (out_valid0 && !started) begin started = 1; stall = 3; held = out_f0; end
            out_ready = (stall == 0);
            in_valid  = (ni < 4);
            if (ni < 4) begin in_z = vz[ni]; in_grs = vg[ni]; end
            #1;
            if (stall > 0 && stall < 3) begin
                checks++;
                if (out_valid0 !== 1'b1 || out_f0 !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b f=%h expected valid=1 f=%h", out_valid0, out_f0, held);
                end
            end
            if (in_valid && !in_ready0) saw_block = 1;
            if (in_valid && in_ready0) ni++;
            if (out_valid0 && out_ready) begin
                checks++;
                if (out_f0 !== ve[no]) begin
                    errors++;
                    $display("FAIL stream_order[%0d]: got %h expected %h", no, out_f0, ve[no]);
                end
                no++;
            end
            @(posedge clk); #1;
            if (stall > 0) stall--;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (no !== 4) begin errors++; $display("FAIL stream_count: got %0d expected 4", no); end
        checks++;
        if (saw_block !== 1'b1) begin errors++; $display("FAIL stall_in_ready: got never-low expected low when full"); end
        checks++;
        if (out_valid0 !== 1'b0) begin errors++; $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] f0, f1; logic [2:0] fl; int lat;
        out_ready = 1'b0; in_valid = 1'b1;
        in_z = {1'b0, 8'h80, 24'hA00000}; in_grs = 3'b000;
        @(posedge clk); #1;
        in_z = {1'b0, 8'h81, 24'hC00000};
        @(posedge clk); #1;
        checks++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_full: got in_ready=%b out_valid=%b expected 0/1", in_ready0, out_valid0);
        end
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid0 !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b expected 0", out_valid0); end
        checks++;
        if (out_f0 !== 32'h0) begin errors++; $display("FAIL midreset_out_f: got %h expected 00000000", out_f0); end
        checks++;
        if (in_ready0 !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready0); end
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid0 !== 1'b0) begin errors++; $display("FAIL midreset_no_ghost: got %b expected 0", out_valid0); end
        run_one({1'b0, 8'h7F, 24'hC00000}, 3'b000, f0, f1, fl, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL post_reset_latency: got %0d expected 2", lat); end
        checks++;
        if (f0 !== 32'h3FC00000) begin errors++; $display("FAIL post_reset_value: got %h expected 3fc00000", f0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_carry_overflow();
        test_zero();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
